// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit-side buffer.
//   UART_BYTE_W     : width of one UART byte.
//   tx_fifo_state_t : handshake FSM states of uart_tx_fifo.
package uart_pkg;

  localparam int unsigned UART_BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    ARM  = 2'd2,
    WAIT = 2'd3
  } tx_fifo_state_t;

endpackage

// File: rtl/sync_fifo_mem.sv
// Synchronous byte FIFO: register array, wrapping pointers and a separate level counter.
// Occupancy flags are registered alongside the level.
// Ports:
//   clk_i        : clock, rising edge
//   reset_i      : synchronous active-high reset (pointers, level, flags)
//   push_i       : enqueue push_data_i; ignored while full_o is set
//   push_data_i  : byte to enqueue
//   pop_i        : dequeue the head byte; ignored while empty_o is set
//   pop_data_o   : head byte, mem[rd_ptr]
//   full_o       : level == depth
//   empty_o      : level == 0
//   level_o      : byte count, 0..depth
module sync_fifo_mem
  import uart_pkg::*;
#(
  parameter int unsigned DepthLog2 = 4
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   push_i,
  input  logic [UART_BYTE_W-1:0] push_data_i,
  input  logic                   pop_i,
  output logic [UART_BYTE_W-1:0] pop_data_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [DepthLog2:0]     level_o
);

  localparam int unsigned Depth = 2 ** DepthLog2;
  localparam logic [DepthLog2:0] LevelFull = (DepthLog2 + 1)'(Depth);

  logic [UART_BYTE_W-1:0] mem_q [Depth];
  logic [DepthLog2-1:0]   wr_ptr_q, wr_ptr_d;
  logic [DepthLog2-1:0]   rd_ptr_q, rd_ptr_d;
  logic [DepthLog2:0]     level_q, level_d;
  logic                   full_q, full_d;
  logic                   empty_q, empty_d;
  logic                   push_ok;
  logic                   pop_ok;

  // Acceptance uses the registered flags, so a write while full is dropped
  // even if a pop frees a slot in the same cycle.
  assign push_ok = push_i & ~full_q;
  assign pop_ok  = pop_i & ~empty_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push_ok, pop_ok})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
    full_d  = (level_d == LevelFull);
    empty_d = (level_d == '0);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  // Storage needs no reset; stale contents are unreachable once pointers clear.
  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  assign pop_data_o = mem_q[rd_ptr_q];
  assign full_o     = full_q;
  assign empty_o    = empty_q;
  assign level_o    = level_q;

endmodule

// File: rtl/uart_tx_fifo.sv
// Byte buffer feeding the UART transmitter. Bytes are queued in sync_fifo_mem and popped one
// at a time whenever the transmitter is idle, each with a single-cycle new_tx_data pulse.
// Optional feature macro: UART_TX_FIFO_OVF_EN adds the sticky overflow output.
// Ports:
//   clock       : clock, rising edge
//   reset       : synchronous active-high reset
//   wr_data     : byte to enqueue
//   wr_en       : enqueue wr_data this cycle (dropped when full)
//   full/empty  : registered occupancy flags
//   level       : byte count, 0..2**DEPTH_LOG2
//   tx_data     : byte presented to the UART; holds until the next pop
//   new_tx_data : one-cycle start pulse for tx_data
//   tx_busy     : UART busy flag
//   overflow    : sticky write-while-full flag (only with UART_TX_FIFO_OVF_EN)
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [UART_BYTE_W-1:0] wr_data,
  input  logic                   wr_en,
  output logic                   full,
  output logic                   empty,
  output logic [DEPTH_LOG2:0]    level,
  output logic [UART_BYTE_W-1:0] tx_data,
  output logic                   new_tx_data,
  input  logic                   tx_busy
`ifdef UART_TX_FIFO_OVF_EN
  , output logic                 overflow
`endif
);

  tx_fifo_state_t         state_q, state_d;
  logic                   pop;
  logic [UART_BYTE_W-1:0] head_data;
  logic [UART_BYTE_W-1:0] tx_data_q, tx_data_d;
  logic                   new_tx_data_q, new_tx_data_d;

  sync_fifo_mem #(
    .DepthLog2 (DEPTH_LOG2)
  ) u_mem (
    .clk_i       (clock),
    .reset_i     (reset),
    .push_i      (wr_en),
    .push_data_i (wr_data),
    .pop_i       (pop),
    .pop_data_o  (head_data),
    .full_o      (full),
    .empty_o     (empty),
    .level_o     (level)
  );

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. ARM gives the UART one cycle to raise tx_busy before it is watched.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (!empty && !tx_busy) begin
          state_d = SEND;
        end
      end
      SEND: state_d = ARM;
      ARM:  state_d = WAIT;
      WAIT: begin
        if (!tx_busy) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic: SEND pops the head byte and loads the registered UART outputs.
  always_comb begin
    pop           = 1'b0;
    tx_data_d     = tx_data_q;
    new_tx_data_d = 1'b0;
    if (state_q == SEND) begin
      pop           = 1'b1;
      tx_data_d     = head_data;
      new_tx_data_d = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      tx_data_q     <= '0;
      new_tx_data_q <= 1'b0;
    end else begin
      tx_data_q     <= tx_data_d;
      new_tx_data_q <= new_tx_data_d;
    end
  end

  assign tx_data     = tx_data_q;
  assign new_tx_data = new_tx_data_q;

`ifdef UART_TX_FIFO_OVF_EN
  logic overflow_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      overflow_q <= 1'b0;
    end else if (wr_en && full) begin
      overflow_q <= 1'b1;
    end
  end

  assign overflow = overflow_q;
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed self-checking bench for uart_tx_fifo with a simple busy-UART model.
module tb_uart_tx_fifo;
  import uart_pkg::*;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] wr_data = 8'h00;
  logic       wr_en = 1'b0;
  logic       full;
  logic       empty;
  logic [4:0] level;
  logic [7:0] tx_data;
  logic       new_tx_data;
  logic       tx_busy;
`ifdef UART_TX_FIFO_OVF_EN
  logic       overflow;
`endif

  int checks = 0;
  int errors = 0;

  // UART model: busy for busy_len cycles after each pulse, plus an external hold.
  logic       force_busy = 1'b0;
  int         busy_cnt = 0;
  logic [7:0] rx_q[$];

  assign tx_busy = force_busy | (busy_cnt != 0);

  uart_tx_fifo #(
    .DEPTH_LOG2 (4)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .wr_data     (wr_data),
    .wr_en       (wr_en),
    .full        (full),
    .empty       (empty),
    .level       (level),
    .tx_data     (tx_data),
    .new_tx_data (new_tx_data),
    .tx_busy     (tx_busy)
`ifdef UART_TX_FIFO_OVF_EN
    , .overflow  (overflow)
`endif
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (new_tx_data === 1'b1) begin
      rx_q.push_back(tx_data);
      checks++;
      if (tx_busy !== 1'b0) begin
        errors++;
        $display("FAIL pulse_while_busy: tx_busy=%b required 0", tx_busy);
      end
      busy_cnt = 10;
    end else if (busy_cnt != 0) begin
      busy_cnt = busy_cnt - 1;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // All task activity happens just after the falling edge, after the UART model.
  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!(dut.state_q == IDLE && tx_busy == 1'b0 && empty == 1'b1) && n < 500) begin
      tick();
      n++;
    end
    checks++;
    if (n >= 500) begin
      errors++;
      $display("FAIL wait_idle: timeout, state=%0d level=%0d required idle", dut.state_q, level);
    end
  endtask

  task automatic test_reset();
    reset   = 1'b1;
    wr_en   = 1'b1;
    wr_data = 8'h77;
    repeat (3) tick();
    reset = 1'b0;
    wr_en = 1'b0;
    checks++;
    if (level !== 5'd0) begin
      errors++; $display("FAIL reset_level: got %0d required 0", level);
    end
    checks++;
    if (empty !== 1'b1 || full !== 1'b0) begin
      errors++; $display("FAIL reset_flags: empty=%b full=%b required 1/0", empty, full);
    end
    checks++;
    if (new_tx_data !== 1'b0 || tx_data !== 8'h00) begin
      errors++; $display("FAIL reset_tx: new=%b data=%h required 0/00", new_tx_data, tx_data);
    end
`ifdef UART_TX_FIFO_OVF_EN
    checks++;
    if (overflow !== 1'b0) begin
      errors++; $display("FAIL reset_overflow: got %b required 0", overflow);
    end
`endif
    repeat (10) tick();
    checks++;
    if (rx_q.size() != 0 || level !== 5'd0) begin
      errors++;
      $display("FAIL reset_no_store: pulses=%0d level=%0d required 0/0", rx_q.size(), level);
    end
  endtask

  task automatic test_single();
    wait_idle();
    rx_q.delete();
    wr_en   = 1'b1;
    wr_data = 8'hA5;
    tick();
    wr_en = 1'b0;
    checks++;
    if (level !== 5'd1 || new_tx_data !== 1'b0) begin
      errors++;
      $display("FAIL single_edge1: level=%0d new=%b required 1/0", level, new_tx_data);
    end
    tick();
    checks++;
    if (new_tx_data !== 1'b0) begin
      errors++; $display("FAIL single_early: new=%b required 0", new_tx_data);
    end
    tick();
    checks++;
    if (new_tx_data !== 1'b1 || tx_data !== 8'hA5 || level !== 5'd0) begin
      errors++;
      $display("FAIL single_pulse: new=%b data=%h level=%0d required 1/a5/0",
               new_tx_data, tx_data, level);
    end
    tick();
    checks++;
    if (new_tx_data !== 1'b0 || tx_data !== 8'hA5) begin
      errors++;
      $display("FAIL single_hold: new=%b data=%h required 0/a5", new_tx_data, tx_data);
    end
    repeat (20) tick();
    checks++;
    if (rx_q.size() != 1 || empty !== 1'b1) begin
      errors++;
      $display("FAIL single_count: pulses=%0d empty=%b required 1/1", rx_q.size(), empty);
    end
  endtask

  task automatic test_burst();
    int peak = 0;
    int n = 0;
    int bad = 0;
    wait_idle();
    rx_q.delete();
    for (int i = 1; i <= 5; i++) begin
      wr_en   = 1'b1;
      wr_data = 8'(i);
      tick();
      if (int'(level) > peak) peak = int'(level);
    end
    wr_en = 1'b0;
    while (rx_q.size() < 5 && n < 400) begin
      tick();
      if (int'(level) > peak) peak = int'(level);
      n++;
    end
    repeat (30) tick();
    checks++;
    if (rx_q.size() != 5) begin
      errors++; $display("FAIL burst_count: got %0d required 5", rx_q.size());
    end
    for (int k = 0; k < rx_q.size() && k < 5; k++) begin
      if (rx_q[k] !== 8'(k + 1)) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL burst_order: %0d bytes out of order, required 0", bad);
    end
    checks++;
    if (peak < 4 || peak > 5) begin
      errors++; $display("FAIL burst_peak: got %0d required 4..5", peak);
    end
    checks++;
    if (level !== 5'd0) begin
      errors++; $display("FAIL burst_drain: level=%0d required 0", level);
    end
  endtask

  task automatic test_full_overflow();
    int n = 0;
    wait_idle();
    rx_q.delete();
    force_busy = 1'b1;
    for (int i = 0; i < 18; i++) begin
      wr_en   = 1'b1;
      wr_data = 8'(8'h10 + i);
      tick();
      if (i == 14) begin
        checks++;
        if (full !== 1'b0 || level !== 5'd15) begin
          errors++; $display("FAIL full_at15: full=%b level=%0d required 0/15", full, level);
        end
      end
      if (i == 15) begin
        checks++;
        if (full !== 1'b1 || level !== 5'd16) begin
          errors++; $display("FAIL full_at16: full=%b level=%0d required 1/16", full, level);
        end
      end
    end
    wr_en = 1'b0;
    tick();
    checks++;
    if (full !== 1'b1 || level !== 5'd16 || empty !== 1'b0 || rx_q.size() != 0) begin
      errors++;
      $display("FAIL full_hold: full=%b level=%0d empty=%b pulses=%0d required 1/16/0/0",
               full, level, empty, rx_q.size());
    end
`ifdef UART_TX_FIFO_OVF_EN
    checks++;
    if (overflow !== 1'b1) begin
      errors++; $display("FAIL overflow_set: got %b required 1", overflow);
    end
`endif
    force_busy = 1'b0;
    while (rx_q.size() < 16 && n < 600) begin
      tick();
      n++;
    end
    repeat (40) tick();
    checks++;
    if (rx_q.size() != 16) begin
      errors++; $display("FAIL full_drain_count: got %0d required 16", rx_q.size());
    end
    for (int k = 0; k < 16 && k < rx_q.size(); k++) begin
      checks++;
      if (rx_q[k] !== 8'(8'h10 + k)) begin
        errors++;
        $display("FAIL full_drain_byte%0d: got %h required %h", k, rx_q[k], 8'(8'h10 + k));
      end
    end
  endtask

  task automatic test_wrap();
    int idx = 0;
    int n = 0;
    int peak = 0;
    int bad = 0;
    wait_idle();
    rx_q.delete();
    while ((idx < 40 || rx_q.size() < 40) && n < 2000) begin
      if (idx < 40 && full == 1'b0) begin
        wr_en   = 1'b1;
        wr_data = 8'(idx);
        idx++;
      end else begin
        wr_en = 1'b0;
      end
      tick();
      if (int'(level) > peak) peak = int'(level);
      n++;
    end
    wr_en = 1'b0;
    repeat (30) tick();
    checks++;
    if (rx_q.size() != 40) begin
      errors++; $display("FAIL wrap_count: got %0d required 40", rx_q.size());
    end
    for (int k = 0; k < 40 && k < rx_q.size(); k++) begin
      if (rx_q[k] !== 8'(k)) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL wrap_order: %0d bytes wrong, required 0", bad);
    end
    checks++;
    if (peak > 16) begin
      errors++; $display("FAIL wrap_level: peak %0d required <= 16", peak);
    end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    wait_idle();
    rx_q.delete();
    for (int i = 0; i < 6; i++) begin
      wr_en   = 1'b1;
      wr_data = 8'(8'h30 + i);
      tick();
    end
    wr_en = 1'b0;
    while (rx_q.size() < 1 && n < 100) begin
      tick();
      n++;
    end
    tick();
    checks++;
    if (dut.state_q !== WAIT) begin
      errors++; $display("FAIL mid_in_wait: state=%0d required %0d", dut.state_q, WAIT);
    end
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    checks++;
    if (level !== 5'd0 || empty !== 1'b1 || dut.state_q !== IDLE) begin
      errors++;
      $display("FAIL mid_reset_state: level=%0d empty=%b state=%0d required 0/1/0",
               level, empty, dut.state_q);
    end
    checks++;
    if (new_tx_data !== 1'b0 || tx_data !== 8'h00) begin
      errors++; $display("FAIL mid_reset_tx: new=%b data=%h required 0/00", new_tx_data, tx_data);
    end
`ifdef UART_TX_FIFO_OVF_EN
    checks++;
    if (overflow !== 1'b0) begin
      errors++; $display("FAIL mid_reset_overflow: got %b required 0", overflow);
    end
`endif
    repeat (60) tick();
    checks++;
    if (rx_q.size() != 1) begin
      errors++; $display("FAIL mid_no_more: pulses=%0d required 1", rx_q.size());
    end
    wr_en   = 1'b1;
    wr_data = 8'h3C;
    tick();
    wr_en = 1'b0;
    n = 0;
    while (rx_q.size() < 2 && n < 100) begin
      tick();
      n++;
    end
    checks++;
    if (rx_q.size() != 2) begin
      errors++; $display("FAIL mid_after_count: pulses=%0d required 2", rx_q.size());
    end else begin
      checks++;
      if (rx_q[1] !== 8'h3C) begin
        errors++; $display("FAIL mid_after_byte: got %h required 3c", rx_q[1]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_full_overflow();
    test_wrap();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
